// File: rtl/multiport_gpr_file.sv
// multiport_gpr_file: two-write, multi-read register file with zero register,
// write-to-read bypass and a pending-write scoreboard.
module multiport_gpr_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [1:0]                       wr_en,
    input  logic [2*ADDR_WIDTH-1:0]          wr_addr,
    input  logic [2*DATA_WIDTH-1:0]          wr_data,
    input  logic [READ_PORTS-1:0]            rd_en,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_busy,
    input  logic                             rsv_en,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr,
    output logic [2**ADDR_WIDTH-1:0]         busy_vec
);
    localparam int NREG = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]       busy, busy_next;
    logic [ADDR_WIDTH-1:0] wa0, wa1;
    logic [DATA_WIDTH-1:0] wd0, wd1;
    logic                  w0, w1;
    logic [DATA_WIDTH-1:0] rd_q [READ_PORTS];
    logic [READ_PORTS-1:0] rd_busy_q;

    assign wa0 = wr_addr[0 +: ADDR_WIDTH];
    assign wa1 = wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
    assign wd0 = wr_data[0 +: DATA_WIDTH];
    assign wd1 = wr_data[DATA_WIDTH +: DATA_WIDTH];
    // address 0 is hardwired, so writes to it are dropped before anything else sees them
    assign w0  = wr_en[0] && wa0 != '0;
    assign w1  = wr_en[1] && wa1 != '0;

    // clears from writes first, then reservation set so a same-cycle reserve wins
    always_comb begin
        busy_next = busy;
        if (w0) busy_next[wa0] = 1'b0;
        if (w1) busy_next[wa1] = 1'b0;
        if (rsv_en && rsv_addr != '0) busy_next[rsv_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // port 1 is assigned last so it takes priority on an address collision
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (w0) regs[wa0] <= wd0;
            if (w1) regs[wa1] <= wd1;
            busy <= busy_next;
        end
    end

    always_ff @(posedge clock) begin
        for (int r = 0; r < READ_PORTS; r++) begin
            if (reset || !rd_en[r]) begin
                rd_q[r]      <= '0;
                rd_busy_q[r] <= 1'b0;
            end else begin
                rd_q[r] <= (w1 && wa1 == rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]) ? wd1 :
                           (w0 && wa0 == rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]) ? wd0 :
                           regs[rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
                rd_busy_q[r] <= busy_next[rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = rd_q[g];
    end

    assign rd_busy  = rd_busy_q;
    assign busy_vec = busy;
endmodule

// File: doc/multiport_gpr_file.md
MULTIPORT_GPR_FILE -- requirements
Module: multiport_gpr_file

Interface
REQ-001 Parameter DATA_WIDTH, 32, bits per register.
REQ-002 Parameter ADDR_WIDTH, 5, address bits; register count = 2**ADDR_WIDTH.
REQ-003 Parameter READ_PORTS, 2, number of read ports (1..8).
REQ-004 clock  input  1  rising-edge clock; reset  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  2  per-write-port enable; port 1 = bit 1.
REQ-006 wr_addr  input  2*ADDR_WIDTH  write addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 wr_data  input  2*DATA_WIDTH  write data, port p at [p*DATA_WIDTH +: DATA_WIDTH].
REQ-008 rd_en  input  READ_PORTS  per-read-port enable.
REQ-009 rd_addr  input  READ_PORTS*ADDR_WIDTH  read addresses, packed as wr_addr.
REQ-010 rd_data  output  READ_PORTS*DATA_WIDTH  registered read data, packed as wr_data.
REQ-011 rd_busy  output  READ_PORTS  registered pending-write flag of addressed register.
REQ-012 rsv_en  input  1  reserve request: mark rsv_addr as pending a write.
REQ-013 rsv_addr  input  ADDR_WIDTH  register to reserve.
REQ-014 busy_vec  output  2**ADDR_WIDTH  current scoreboard, bit i = register i pending.

Function
REQ-015 Register 0 SHALL always read 0 and never be busy; writes and reservations to address 0 SHALL be ignored.
REQ-016 Write: on a clock edge with wr_en[p]=1 and reset=0, regs[wr_addr_p] SHALL take wr_data_p.
REQ-017 Both write ports to the same nonzero address in one cycle: port 1 data SHALL win.
REQ-018 Read latency: rd_data/rd_busy for port r SHALL reflect rd_addr_r sampled at the previous edge (one cycle).
REQ-019 Bypass: if a write to rd_addr_r occurs in the sampling cycle, rd_data_r SHALL return that write data (port-1-priority applied), not the stale array value.
REQ-020 rd_en_r=0 SHALL register rd_data_r=0 and rd_busy_r=0.
REQ-021 Scoreboard: rsv_en=1 SHALL set busy bit rsv_addr at the edge; any wr_en[p]=1 SHALL clear the busy bit of wr_addr_p at the edge.
REQ-022 Reserve and write to the same address in one cycle: set SHALL win (busy stays 1, data still written).
REQ-023 rd_busy_r SHALL equal busy bit of rd_addr_r after that edge's set/clear updates (reserve in sampling cycle reads busy=1; write-only clear reads busy=0).
REQ-024 busy_vec SHALL be the registered scoreboard, bit 0 constant 0.
REQ-025 Writes to non-busy registers SHALL be permitted and leave busy bits unchanged except as in REQ-021.

Reset
REQ-026 While reset=1 at an edge, all registers SHALL clear to 0, all busy bits to 0, rd_data and rd_busy to 0; writes, reservations and reads in that cycle SHALL be discarded.
REQ-027 Deassertion mid-sequence SHALL need no warm-up: the first cycle with reset=0 SHALL accept writes, reads and reservations normally.

Verification
REQ-028 Write port 0 addr 3 = 0x12345678, next cycle read port 0 addr 3 -> rd_data_0 = 0x12345678 one cycle later.
REQ-029 Same cycle: port 0 writes addr 7 = 0xAAAA0000, port 1 writes addr 7 = 0x5555FFFF, read addr 7 -> rd_data = 0x5555FFFF next cycle, array holds 0x5555FFFF.
REQ-030 Write addr 0 = 0xFFFFFFFF and reserve addr 0, read addr 0 -> rd_data=0, rd_busy=0, busy_vec[0]=0.
REQ-031 Reserve addr 9; next cycle read 9 -> rd_busy=1; then write 9 = 0x42 while reading 9 -> rd_data=0x42, rd_busy=0, busy_vec[9]=0.
REQ-032 Reserve and write addr 12 = 0x99 in one cycle -> busy_vec[12]=1, later read 12 returns 0x99 with rd_busy=1.
REQ-033 Load addrs 1..31 with nonzero data and reserve several, assert reset one cycle -> all reads 0, busy_vec=0; first post-reset write/read pair behaves per REQ-028.
